// File: rtl/qpu_exu_disp_oitf_pkg.sv
// Shared types, default sizes and helpers for the QPU dispatch stage and its OITF.
package qpu_disp_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int RFIDX_W_DEF    = 5;
    localparam int OITF_DEPTH_DEF = 4;
    localparam int QUBIT_NUM_DEF  = 8;

    // Entry fields are sized for the widest supported build; narrower builds
    // zero-extend on write and slice on read.
    localparam int RFIDX_W_MAX    = 8;
    localparam int QUBIT_NUM_MAX  = 64;

    typedef struct packed {
        logic                     valid;
        logic                     rdwen;
        logic [RFIDX_W_MAX-1:0]   rdidx;
        logic [QUBIT_NUM_MAX-1:0] qmask;
    } oitf_ent_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/qpu_exu_disp_oitf_if.sv
// Decoder -> dispatch -> ALU/long-pipe handshake bundle plus the OITF retire port.
interface qpu_exu_disp_oitf_if
    import qpu_disp_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RFIDX_W    = RFIDX_W_DEF,
    parameter int OITF_DEPTH = OITF_DEPTH_DEF,
    parameter int QUBIT_NUM  = QUBIT_NUM_DEF
);
    localparam int ITAG_W = clog2(OITF_DEPTH);

    logic                 disp_i_valid;
    logic                 disp_i_ready;
    logic                 disp_i_rs1en;
    logic                 disp_i_rs2en;
    logic                 disp_i_rs1x0;
    logic                 disp_i_rs2x0;
    logic [RFIDX_W-1:0]   disp_i_rs1idx;
    logic [RFIDX_W-1:0]   disp_i_rs2idx;
    logic [XLEN-1:0]      disp_i_rs1;
    logic [XLEN-1:0]      disp_i_rs2;
    logic                 disp_i_rdwen;
    logic [RFIDX_W-1:0]   disp_i_rdidx;
    logic                 disp_i_longpipe;
    logic                 disp_i_measure;
    logic                 disp_i_nqf;
    logic [QUBIT_NUM-1:0] disp_i_qubitlist;

    logic                 disp_o_alu_valid;
    logic                 disp_o_alu_ready;
    logic [XLEN-1:0]      disp_o_alu_rs1;
    logic [XLEN-1:0]      disp_o_alu_rs2;
    logic                 disp_o_alu_rdwen;
    logic [RFIDX_W-1:0]   disp_o_alu_rdidx;
    logic [ITAG_W-1:0]    disp_o_alu_itag;

    logic                 oitf_ret_ena;
    logic                 oitf_ret_rdwen;
    logic [RFIDX_W-1:0]   oitf_ret_rdidx;
    logic [QUBIT_NUM-1:0] oitf_ret_qmask;
    logic                 oitf_empty;
    logic                 oitf_full;

    modport master (
        output disp_i_valid, disp_i_rs1en, disp_i_rs2en, disp_i_rs1x0, disp_i_rs2x0,
               disp_i_rs1idx, disp_i_rs2idx, disp_i_rs1, disp_i_rs2, disp_i_rdwen,
               disp_i_rdidx, disp_i_longpipe, disp_i_measure, disp_i_nqf, disp_i_qubitlist,
               disp_o_alu_ready, oitf_ret_ena,
        input  disp_i_ready, disp_o_alu_valid, disp_o_alu_rs1, disp_o_alu_rs2,
               disp_o_alu_rdwen, disp_o_alu_rdidx, disp_o_alu_itag,
               oitf_ret_rdwen, oitf_ret_rdidx, oitf_ret_qmask, oitf_empty, oitf_full
    );

    modport slave (
        input  disp_i_valid, disp_i_rs1en, disp_i_rs2en, disp_i_rs1x0, disp_i_rs2x0,
               disp_i_rs1idx, disp_i_rs2idx, disp_i_rs1, disp_i_rs2, disp_i_rdwen,
               disp_i_rdidx, disp_i_longpipe, disp_i_measure, disp_i_nqf, disp_i_qubitlist,
               disp_o_alu_ready, oitf_ret_ena,
        output disp_i_ready, disp_o_alu_valid, disp_o_alu_rs1, disp_o_alu_rs2,
               disp_o_alu_rdwen, disp_o_alu_rdidx, disp_o_alu_itag,
               oitf_ret_rdwen, oitf_ret_rdidx, oitf_ret_qmask, oitf_empty, oitf_full
    );

endinterface

// File: rtl/qpu_exu_disp_oitf_fifo.sv
// OITF storage: in-order ring with wrap-bit pointers, per-entry index matches and qmask OR.
// Macro QPU_DISP_OITF_RET_BYPASS_EN hides the retiring head entry from same-cycle checks.
module qpu_oitf_fifo
    import qpu_disp_pkg::*;
#(
    parameter int  DEPTH     = OITF_DEPTH_DEF,
    parameter int  RFIDX_W   = RFIDX_W_DEF,
    parameter int  QUBIT_NUM = QUBIT_NUM_DEF,
    localparam int IDX_W     = clog2(DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_alloc,
    input  logic                  i_alloc_rdwen,
    input  logic [RFIDX_W-1:0]    i_alloc_rdidx,
    input  logic [QUBIT_NUM-1:0]  i_alloc_qmask,
    input  logic                  i_ret,
    input  logic [RFIDX_W-1:0]    i_idx0,
    input  logic [RFIDX_W-1:0]    i_idx1,
    input  logic [RFIDX_W-1:0]    i_idx2,
    output logic [DEPTH-1:0]      o_match0,
    output logic [DEPTH-1:0]      o_match1,
    output logic [DEPTH-1:0]      o_match2,
    output logic [QUBIT_NUM-1:0]  o_qmask_or,
    output logic                  o_full_chk,
    output logic [IDX_W-1:0]      o_itag,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_ret_rdwen,
    output logic [RFIDX_W-1:0]    o_ret_rdidx,
    output logic [QUBIT_NUM-1:0]  o_ret_qmask
);
    localparam int PTR_W = IDX_W + 1;

    oitf_ent_t                         r_ent [DEPTH];
    logic [PTR_W-1:0]                  r_wptr, r_rptr;
    logic [IDX_W-1:0]                  w_widx, w_ridx;
    logic                              w_ret_fire;
    logic [DEPTH-1:0]                  w_live;
    logic [DEPTH-1:0][QUBIT_NUM-1:0]   w_qm;

    assign w_widx     = r_wptr[IDX_W-1:0];
    assign w_ridx     = r_rptr[IDX_W-1:0];
    assign o_itag     = w_widx;
    assign o_empty    = (r_wptr == r_rptr);
    assign o_full     = (w_widx == w_ridx) & (r_wptr[IDX_W] != r_rptr[IDX_W]);
    assign w_ret_fire = i_ret & ~o_empty;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) w_live[i] = r_ent[i].valid;
`ifdef QPU_DISP_OITF_RET_BYPASS_EN
        if (w_ret_fire) w_live[w_ridx] = 1'b0;
`endif
    end

`ifdef QPU_DISP_OITF_RET_BYPASS_EN
    assign o_full_chk = o_full & ~w_ret_fire;
`else
    assign o_full_chk = o_full;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic w_rdhit;
        assign w_rdhit     = w_live[g] & r_ent[g].rdwen;
        assign o_match0[g] = w_rdhit & (r_ent[g].rdidx[RFIDX_W-1:0] == i_idx0);
        assign o_match1[g] = w_rdhit & (r_ent[g].rdidx[RFIDX_W-1:0] == i_idx1);
        assign o_match2[g] = w_rdhit & (r_ent[g].rdidx[RFIDX_W-1:0] == i_idx2);
        assign w_qm[g]     = w_live[g] ? r_ent[g].qmask[QUBIT_NUM-1:0] : '0;
    end

    always_comb begin
        o_qmask_or = '0;
        for (int i = 0; i < DEPTH; i++) o_qmask_or = o_qmask_or | w_qm[i];
    end

    assign o_ret_rdwen = ~o_empty & r_ent[w_ridx].rdwen;
    assign o_ret_rdidx = o_empty ? '0 : r_ent[w_ridx].rdidx[RFIDX_W-1:0];
    assign o_ret_qmask = o_empty ? '0 : r_ent[w_ridx].qmask[QUBIT_NUM-1:0];

    // With the retire bypass a full ring can retire and allocate the same slot;
    // the allocate write comes last so the new entry wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else begin
            if (w_ret_fire) begin
                r_ent[w_ridx].valid <= 1'b0;
                r_rptr              <= r_rptr + PTR_W'(1);
            end
            if (i_alloc) begin
                r_ent[w_widx].valid <= 1'b1;
                r_ent[w_widx].rdwen <= i_alloc_rdwen;
                r_ent[w_widx].rdidx <= RFIDX_W_MAX'(i_alloc_rdidx);
                r_ent[w_widx].qmask <= QUBIT_NUM_MAX'(i_alloc_qmask);
                r_wptr              <= r_wptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/qpu_exu_disp_oitf.sv
// QPU dispatch stage: RAW/WAW and qubit hazard stall against the OITF, operand forwarding.
// Macro QPU_DISP_OITF_RET_BYPASS_EN lets a same-cycle retire unblock dispatch.
module qpu_exu_disp_oitf
    import qpu_disp_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RFIDX_W    = RFIDX_W_DEF,
    parameter int OITF_DEPTH = OITF_DEPTH_DEF,
    parameter int QUBIT_NUM  = QUBIT_NUM_DEF
)(
    input  logic               clk,
    input  logic               rst,
    qpu_exu_disp_oitf_if.slave disp
);
    logic [OITF_DEPTH-1:0] w_m_rs1, w_m_rs2, w_m_rd;
    logic [QUBIT_NUM-1:0]  w_qmask_inflight;
    logic                  w_full_chk;
    logic                  w_haz_rs1, w_haz_rs2, w_haz_rd, w_haz_full, w_haz_q;
    logic                  w_stall, w_fire, w_alloc;

    assign w_haz_rs1  = disp.disp_i_rs1en & ~disp.disp_i_rs1x0 & (|w_m_rs1);
    assign w_haz_rs2  = disp.disp_i_rs2en & ~disp.disp_i_rs2x0 & (|w_m_rs2);
    assign w_haz_rd   = disp.disp_i_rdwen & (|w_m_rd);
    assign w_haz_full = disp.disp_i_longpipe & w_full_chk;
    assign w_haz_q    = (disp.disp_i_measure | disp.disp_i_nqf)
                      & (|(disp.disp_i_qubitlist & w_qmask_inflight));
    assign w_stall    = w_haz_rs1 | w_haz_rs2 | w_haz_rd | w_haz_full | w_haz_q;

    assign disp.disp_o_alu_valid = disp.disp_i_valid & ~w_stall;
    assign disp.disp_i_ready     = disp.disp_o_alu_ready & ~w_stall;
    assign w_fire                = disp.disp_i_valid & disp.disp_i_ready;
    assign w_alloc               = w_fire & disp.disp_i_longpipe;

    assign disp.disp_o_alu_rs1   = disp.disp_i_rs1x0 ? XLEN'(0) : disp.disp_i_rs1;
    assign disp.disp_o_alu_rs2   = disp.disp_i_rs2x0 ? XLEN'(0) : disp.disp_i_rs2;
    assign disp.disp_o_alu_rdwen = disp.disp_i_rdwen;
    assign disp.disp_o_alu_rdidx = disp.disp_i_rdidx;

    // Only measurements reserve qubits; FMR just checks them.
    qpu_oitf_fifo #(
        .DEPTH     (OITF_DEPTH),
        .RFIDX_W   (RFIDX_W),
        .QUBIT_NUM (QUBIT_NUM)
    ) u_oitf (
        .clk           (clk),
        .rst           (rst),
        .i_alloc       (w_alloc),
        .i_alloc_rdwen (disp.disp_i_rdwen),
        .i_alloc_rdidx (disp.disp_i_rdidx),
        .i_alloc_qmask (disp.disp_i_measure ? disp.disp_i_qubitlist : '0),
        .i_ret         (disp.oitf_ret_ena),
        .i_idx0        (disp.disp_i_rs1idx),
        .i_idx1        (disp.disp_i_rs2idx),
        .i_idx2        (disp.disp_i_rdidx),
        .o_match0      (w_m_rs1),
        .o_match1      (w_m_rs2),
        .o_match2      (w_m_rd),
        .o_qmask_or    (w_qmask_inflight),
        .o_full_chk    (w_full_chk),
        .o_itag        (disp.disp_o_alu_itag),
        .o_full        (disp.oitf_full),
        .o_empty       (disp.oitf_empty),
        .o_ret_rdwen   (disp.oitf_ret_rdwen),
        .o_ret_rdidx   (disp.oitf_ret_rdidx),
        .o_ret_qmask   (disp.oitf_ret_qmask)
    );

endmodule

// File: tb/tb_qpu_exu_disp_oitf.sv
// Bench for qpu_exu_disp_oitf: directed scenarios plus random traffic against a queue model.
module tb_qpu_exu_disp_oitf;
    import qpu_disp_pkg::*;

    localparam int XLEN = 32, RFIDX_W = 5, DEPTH = 4, QN = 8, ITAG_W = 2;
    localparam int OBS_W = 6 + ITAG_W + 2*RFIDX_W + QN + 2*XLEN;
`ifdef QPU_DISP_OITF_RET_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qpu_exu_disp_oitf_if #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .OITF_DEPTH(DEPTH), .QUBIT_NUM(QN)) bus ();
    qpu_exu_disp_oitf #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .OITF_DEPTH(DEPTH), .QUBIT_NUM(QN))
        dut (.clk(clk), .rst(rst), .disp(bus));

    // Model: in-order list of outstanding long-pipe instructions, oldest first.
    oitf_ent_t mq[$];
    int n_alloc;
    int checks, errors;

    function automatic logic m_ret_fire();
        return bus.oitf_ret_ena && (mq.size() > 0);
    endfunction

    function automatic logic m_stall();
        int skip = (BYP && m_ret_fire()) ? 1 : 0;
        logic st = 1'b0;
        logic [QN-1:0] infl = '0;
        for (int k = skip; k < mq.size(); k++) begin
            if (mq[k].rdwen && bus.disp_i_rs1en && !bus.disp_i_rs1x0 &&
                mq[k].rdidx == RFIDX_W_MAX'(bus.disp_i_rs1idx)) st = 1'b1;
            if (mq[k].rdwen && bus.disp_i_rs2en && !bus.disp_i_rs2x0 &&
                mq[k].rdidx == RFIDX_W_MAX'(bus.disp_i_rs2idx)) st = 1'b1;
            if (mq[k].rdwen && bus.disp_i_rdwen &&
                mq[k].rdidx == RFIDX_W_MAX'(bus.disp_i_rdidx)) st = 1'b1;
            infl = infl | mq[k].qmask[QN-1:0];
        end
        if (bus.disp_i_longpipe && (mq.size() - skip) == DEPTH) st = 1'b1;
        if ((bus.disp_i_measure || bus.disp_i_nqf) && (bus.disp_i_qubitlist & infl) != '0) st = 1'b1;
        return st;
    endfunction

    function automatic logic [OBS_W-1:0] m_obs();
        logic st = m_stall();
        oitf_ent_t h = (mq.size() > 0) ? mq[0] : '0;
        return {bus.disp_i_valid & ~st, bus.disp_o_alu_ready & ~st, ITAG_W'(n_alloc % DEPTH),
                mq.size() == DEPTH, mq.size() == 0, h.rdwen, h.rdidx[RFIDX_W-1:0], h.qmask[QN-1:0],
                (bus.disp_i_rs1x0 ? XLEN'(0) : bus.disp_i_rs1), (bus.disp_i_rs2x0 ? XLEN'(0) : bus.disp_i_rs2),
                bus.disp_i_rdwen, bus.disp_i_rdidx};
    endfunction

    function automatic logic [OBS_W-1:0] d_obs();
        return {bus.disp_o_alu_valid, bus.disp_i_ready, bus.disp_o_alu_itag, bus.oitf_full,
                bus.oitf_empty, bus.oitf_ret_rdwen, bus.oitf_ret_rdidx, bus.oitf_ret_qmask,
                bus.disp_o_alu_rs1, bus.disp_o_alu_rs2, bus.disp_o_alu_rdwen, bus.disp_o_alu_rdidx};
    endfunction

    // Advance the model with the inputs currently driven, then clock the DUT.
    task automatic tick();
        logic st, fire, rf;
        oitf_ent_t e;
        if (rst) begin
            mq.delete();
            n_alloc = 0;
        end else begin
            st   = m_stall();
            rf   = m_ret_fire();
            fire = bus.disp_i_valid && bus.disp_o_alu_ready && !st;
            if (rf) void'(mq.pop_front());
            if (fire && bus.disp_i_longpipe) begin
                e.valid = 1'b1;
                e.rdwen = bus.disp_i_rdwen;
                e.rdidx = RFIDX_W_MAX'(bus.disp_i_rdidx);
                e.qmask = bus.disp_i_measure ? QUBIT_NUM_MAX'(bus.disp_i_qubitlist) : '0;
                mq.push_back(e);
                n_alloc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_i_valid = 1'b0;  bus.disp_i_rs1en = 1'b0;  bus.disp_i_rs2en = 1'b0;
        bus.disp_i_rs1x0 = 1'b0;  bus.disp_i_rs2x0 = 1'b0;  bus.disp_i_rs1idx = '0;
        bus.disp_i_rs2idx = '0;   bus.disp_i_rs1 = '0;      bus.disp_i_rs2 = '0;
        bus.disp_i_rdwen = 1'b0;  bus.disp_i_rdidx = '0;    bus.disp_i_longpipe = 1'b0;
        bus.disp_i_measure = 1'b0; bus.disp_i_nqf = 1'b0;   bus.disp_i_qubitlist = '0;
        bus.disp_o_alu_ready = 1'b1; bus.oitf_ret_ena = 1'b0;
    endtask

    task automatic drv(input logic lp, input logic rdwen, input int rd, input logic rs1en,
                       input int rs1, input logic meas, input logic nqf, input logic [QN-1:0] ql);
        idle();
        bus.disp_i_valid    = 1'b1;
        bus.disp_i_longpipe = lp;
        bus.disp_i_rdwen    = rdwen;
        bus.disp_i_rdidx    = RFIDX_W'(rd);
        bus.disp_i_rs1en    = rs1en;
        bus.disp_i_rs1idx   = RFIDX_W'(rs1);
        bus.disp_i_measure  = meas;
        bus.disp_i_nqf      = nqf;
        bus.disp_i_qubitlist = ql;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        drv(1, 1, 3, 0, 0, 0, 0, '0);
        tick();
        do_reset();
        checks++;
        if (bus.oitf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.oitf_empty); end
        checks++;
        if (bus.oitf_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.oitf_full); end
        checks++;
        if ({bus.oitf_ret_rdwen, bus.oitf_ret_rdidx, bus.oitf_ret_qmask} !== 14'h0)
            begin errors++; $display("FAIL reset_ret: got %h want 0", {bus.oitf_ret_rdwen, bus.oitf_ret_rdidx, bus.oitf_ret_qmask}); end
        checks++;
        if (bus.disp_o_alu_itag !== 2'd0) begin errors++; $display("FAIL reset_itag: got %0d want 0", bus.disp_o_alu_itag); end
    endtask

    task automatic test_alu_pass();
        drv(0, 1, 18, 0, 0, 0, 0, '0);
        #1;
        checks++;
        if ({bus.disp_o_alu_valid, bus.disp_o_alu_rdidx} !== {1'b1, 5'd18})
            begin errors++; $display("FAIL alu_pass: valid/rd %b/%0d want 1/18", bus.disp_o_alu_valid, bus.disp_o_alu_rdidx); end
        tick();
        idle();
        #1;
        checks++;
        if (bus.oitf_empty !== 1'b1) begin errors++; $display("FAIL alu_no_alloc: empty %b want 1", bus.oitf_empty); end
    endtask

    task automatic test_raw();
        drv(1, 1, 18, 0, 0, 0, 0, '0);
        #1;
        checks++;
        if (bus.disp_i_ready !== 1'b1) begin errors++; $display("FAIL raw_load: ready %b want 1", bus.disp_i_ready); end
        tick();
        drv(0, 1, 5, 1, 18, 0, 0, '0);
        #1;
        checks++;
        if (bus.disp_i_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: ready %b want 0", bus.disp_i_ready); end
        checks++;
        if (bus.oitf_ret_rdidx !== 5'd18) begin errors++; $display("FAIL raw_head: ret_rdidx %0d want 18", bus.oitf_ret_rdidx); end
        tick();
        bus.oitf_ret_ena = 1'b1;
        #1;
        checks++;
        if (bus.disp_i_ready !== BYP) begin errors++; $display("FAIL raw_ret_cycle: ready %b want %b", bus.disp_i_ready, BYP); end
        tick();
        bus.oitf_ret_ena = 1'b0;
        #1;
        checks++;
        if (bus.disp_i_ready !== 1'b1) begin errors++; $display("FAIL raw_after_ret: ready %b want 1", bus.disp_i_ready); end
        tick();
        idle();
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                drv(1, 1, 8*r + i + 1, 0, 0, 0, 0, '0);
                #1;
                checks++;
                if ({bus.disp_i_ready, bus.disp_o_alu_itag} !== {1'b1, ITAG_W'(i)})
                    begin errors++; $display("FAIL wrap_itag r%0d i%0d: ready/itag %b/%0d want 1/%0d", r, i, bus.disp_i_ready, bus.disp_o_alu_itag, i); end
                tick();
            end
            drv(1, 1, 30, 0, 0, 0, 0, '0);
            #1;
            checks++;
            if ({bus.oitf_full, bus.disp_i_ready} !== 2'b10)
                begin errors++; $display("FAIL wrap_full r%0d: full/ready %b%b want 10", r, bus.oitf_full, bus.disp_i_ready); end
            idle();
            bus.oitf_ret_ena = 1'b1;
            for (int i = 0; i < DEPTH; i++) tick();
            bus.oitf_ret_ena = 1'b0;
            #1;
            checks++;
            if ({bus.oitf_empty, bus.oitf_full} !== 2'b10)
                begin errors++; $display("FAIL wrap_drain r%0d: empty/full %b%b want 10", r, bus.oitf_empty, bus.oitf_full); end
        end
    endtask

    task automatic test_qubit();
        drv(1, 0, 0, 0, 0, 1, 0, 8'b0000_0010);
        tick();
        drv(0, 1, 7, 0, 0, 0, 1, 8'b0000_0010);
        #1;
        checks++;
        if (bus.disp_i_ready !== 1'b0) begin errors++; $display("FAIL qubit_overlap: ready %b want 0", bus.disp_i_ready); end
        bus.disp_i_qubitlist = 8'b0000_0100;
        #1;
        checks++;
        if (bus.disp_i_ready !== 1'b1) begin errors++; $display("FAIL qubit_disjoint: ready %b want 1", bus.disp_i_ready); end
        tick();
        idle();
        bus.oitf_ret_ena = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_x0_empty_ret();
        do_reset();
        idle();
        bus.disp_i_valid = 1'b1;
        bus.disp_i_rs1x0 = 1'b1;
        bus.disp_i_rs1   = 32'hDEADBEEF;
        bus.disp_i_rs2   = 32'h1234_5678;
        #1;
        checks++;
        if ({bus.disp_o_alu_rs1, bus.disp_o_alu_rs2} !== {32'h0, 32'h1234_5678})
            begin errors++; $display("FAIL x0_operand: rs1/rs2 %h/%h want 0/12345678", bus.disp_o_alu_rs1, bus.disp_o_alu_rs2); end
        idle();
        bus.oitf_ret_ena = 1'b1;
        tick();
        tick();
        bus.oitf_ret_ena = 1'b0;
        drv(1, 1, 2, 0, 0, 0, 0, '0);
        #1;
        checks++;
        if ({bus.oitf_empty, bus.disp_o_alu_itag} !== {1'b1, 2'd0})
            begin errors++; $display("FAIL empty_ret_ignored: empty/itag %b/%0d want 1/0", bus.oitf_empty, bus.disp_o_alu_itag); end
        tick();
        idle();
        #1;
        checks++;
        if (bus.oitf_empty !== 1'b0) begin errors++; $display("FAIL alloc_after_empty_ret: empty %b want 0", bus.oitf_empty); end
    endtask

    task automatic test_full_retire();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drv(1, 1, i + 1, 0, 0, 0, 0, '0);
            tick();
        end
        drv(1, 1, 9, 0, 0, 0, 0, '0);
        bus.oitf_ret_ena = 1'b1;
        #1;
        checks++;
        if (bus.disp_i_ready !== BYP) begin errors++; $display("FAIL full_ret_cycle: ready %b want %b", bus.disp_i_ready, BYP); end
        tick();
        bus.oitf_ret_ena = 1'b0;
        #1;
        checks++;
        if ({bus.oitf_full, bus.disp_i_ready} !== {BYP, !BYP})
            begin errors++; $display("FAIL full_ret_next: full/ready %b%b want %b%b", bus.oitf_full, bus.disp_i_ready, BYP, !BYP); end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.oitf_full, bus.oitf_ret_rdidx} !== {1'b1, 5'd2})
            begin errors++; $display("FAIL full_ret_count: full/head %b/%0d want 1/2", bus.oitf_full, bus.oitf_ret_rdidx); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            bus.disp_i_valid     = ($urandom_range(0, 3) != 0);
            bus.disp_o_alu_ready = ($urandom_range(0, 4) != 0);
            bus.disp_i_rs1en     = $urandom_range(0, 1);
            bus.disp_i_rs2en     = $urandom_range(0, 1);
            bus.disp_i_rs1x0     = ($urandom_range(0, 7) == 0);
            bus.disp_i_rs2x0     = ($urandom_range(0, 7) == 0);
            bus.disp_i_rs1idx    = RFIDX_W'($urandom_range(0, 7));
            bus.disp_i_rs2idx    = RFIDX_W'($urandom_range(0, 7));
            bus.disp_i_rdidx     = RFIDX_W'($urandom_range(0, 7));
            bus.disp_i_rdwen     = $urandom_range(0, 1);
            bus.disp_i_rs1       = $urandom;
            bus.disp_i_rs2       = $urandom;
            bus.disp_i_longpipe  = ($urandom_range(0, 2) != 0);
            bus.disp_i_measure   = ($urandom_range(0, 3) == 0);
            bus.disp_i_nqf       = ($urandom_range(0, 3) == 0);
            bus.disp_i_qubitlist = QN'(1 << $urandom_range(0, QN - 1));
            bus.oitf_ret_ena     = ($urandom_range(0, 9) < 4);
            #1;
            checks++;
            if (d_obs() !== m_obs())
                begin errors++; $display("FAIL random_obs cyc %0d: dut %h model %h", c, d_obs(), m_obs()); end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        n_alloc = 0;
        rst     = 1'b1;
        idle();
        test_reset();
        test_alu_pass();
        test_raw();
        test_full_wrap();
        test_qubit();
        test_x0_empty_ret();
        test_full_retire();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qpu_exu_disp_oitf.md
Name: qpu_exu_disp_oitf

Overview:
Parametrised next-generation QPU dispatch stage with an integrated outstanding-instruction track FIFO (OITF).
- Sits between the decoder and the ALU / long-pipe units.
- Checks classical register RAW/WAW hazards and in-flight measurement qubit hazards against the OITF, then forwards the operands.
- Allocates an OITF entry for each long-pipe instruction; entries retire in order.

Parameters:
XLEN, 32, classical register data width
RFIDX_W, 5, register index width
OITF_DEPTH, 4, OITF entry count (power of two, ≥2)
QUBIT_NUM, 8, qubit count; width of qubit lists and masks

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
disp_i_valid  in  1  decoded instruction valid
disp_i_ready  out  1  dispatch accepts instruction
disp_i_rs1en / disp_i_rs2en  in  1 each  source read enables
disp_i_rs1x0 / disp_i_rs2x0  in  1 each  source is x0
disp_i_rs1idx / disp_i_rs2idx  in  RFIDX_W each  source indices
disp_i_rs1 / disp_i_rs2  in  XLEN each  register file read data
disp_i_rdwen  in  1  destination write enable
disp_i_rdidx  in  RFIDX_W  destination index
disp_i_longpipe  in  1  instruction completes via long pipe
disp_i_measure  in  1  measure instruction
disp_i_nqf  in  1  instruction needs qubit flags (FMR)
disp_i_qubitlist  in  QUBIT_NUM  qubits touched by measure/FMR
disp_o_alu_valid  out  1  to ALU
disp_o_alu_ready  in  1  ALU accepts
disp_o_alu_rs1 / disp_o_alu_rs2  out  XLEN each  operands; 0 when x0
disp_o_alu_rdwen  out  1  forwarded rdwen
disp_o_alu_rdidx  out  RFIDX_W  forwarded rdidx
disp_o_alu_itag  out  log2(OITF_DEPTH)  OITF entry index allocated
oitf_ret_ena  in  1  long pipe retires head entry
oitf_ret_rdwen  out  1  head entry rdwen
oitf_ret_rdidx  out  RFIDX_W  head entry rdidx
oitf_ret_qmask  out  QUBIT_NUM  head entry qubit mask
oitf_empty  out  1  no entries valid
oitf_full  out  1  all entries valid

Behaviour:
- Dispatch is combinational in the valid/ready direction.
  - disp_o_alu_valid = disp_i_valid & ~stall
  - disp_i_ready = disp_o_alu_ready & ~stall
  - fire = disp_i_valid & disp_i_ready
- stall is the OR of the following; each compare covers only valid entries:
  - rs1en & ~rs1x0 & rs1idx equals a valid entry's rdidx with rdwen=1
  - the same check for rs2
  - rdwen & rdidx equals a valid entry's rdidx with rdwen=1 (WAW)
  - longpipe & oitf_full
  - (measure | nqf) & |(qubitlist & inflight_qmask), where inflight_qmask is the OR of the qmasks of valid entries
- Allocation, on fire & longpipe:
  - entry[wptr] ← {valid=1, rdwen, rdidx, qmask = measure ? qubitlist : 0}
  - wptr increments.
  - disp_o_alu_itag = wptr[low bits] in the same cycle.
- Retire, on oitf_ret_ena & ~oitf_empty:
  - entry[rptr].valid ← 0; rptr increments.
  - oitf_ret_ena while empty is ignored; no pointer change.
- Pointers are log2(OITF_DEPTH)+1 bits; the MSB is the wrap bit.
  - empty: pointers equal.
  - full: low bits equal and MSB differs.
  - Wrap-around from DEPTH-1 to 0 toggles the MSB.
- Simultaneous alloc and retire: both take effect. The entry count is unchanged unless blocked by full (see Optional Feature).
- oitf_ret_* outputs are registered entry contents at rptr. They are 0 when empty.
- Operand outputs: rs1/rs2 are forced to 0 when the matching x0 input is set. Otherwise they pass through.
- Reset: all entry valid=0, wptr=rptr=0, oitf_empty=1, oitf_full=0, oitf_ret_*=0. Reset mid-operation discards all in-flight entries. disp_o_alu_valid follows disp_i_valid in the cycle after reset, subject to stall.

Optional Feature:
QPU_DISP_OITF_RET_BYPASS_EN
- Defined: a retiring head entry (oitf_ret_ena & ~empty) is excluded from hazard, qmask and full checks in the same cycle. Dispatch can therefore fire into a full OITF when a retire happens in that cycle.
- Undefined: checks use the registered entry state only. Dispatch waits one cycle after the retire.

Decomposition:
- Shared package qpu_disp_pkg holds:
  - OITF entry struct {valid, rdwen, rdidx, qmask}
  - pointer-width function clog2
  - default parameter constants
- One sub-module, qpu_oitf_fifo: the entry storage, pointers, full/empty logic, and the per-entry match vector against three indices plus the qmask OR. Dispatch hazard and handshake logic stay in the top.

Test Plan:
- Reset, then ADD (rd=18) with longpipe=0 → alu_valid=1 the same cycle, no allocation, oitf_empty stays 1.
- Longpipe LOAD rd=18, then ADD rs1=18 → ADD stalls (disp_i_ready=0); after oitf_ret_ena it fires the next cycle (the same cycle with bypass).
- Dispatch 4 longpipe instructions (rd 1..4), DEPTH=4 → oitf_full=1, 5th stalls; itags 0,1,2,3; the next round after retires uses itag 0 again and the wrap bit toggles.
- Measure with qubitlist=8'b0000_0010 in flight, then FMR with qubitlist=8'b0000_0010 → stalls; FMR with 8'b0000_0100 → fires.
- rs1x0=1 with disp_i_rs1=32'hDEADBEEF → disp_o_alu_rs1=0; oitf_ret_ena on an empty OITF → pointers stay 0.
- Full OITF with same-cycle retire and a longpipe dispatch → with the macro, fires and the count stays 4; without it, stalls one cycle.
